// File: rtl/insn_buffer.sv
// Dual-lane instruction buffer between fetch and decode: circular FIFO of
// {pc, insn, ptab_addr} with 0/1/2 push and pop per cycle and synchronous flush.
module insn_buffer #(
  parameter int DEPTH  = 8,
  parameter int PTAB_W = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              flush,
  input  logic              if_ib_valid_ns,
  input  logic              if_ib_valid_0,
  input  logic              if_ib_valid_1,
  input  logic [31:0]       if_ib_pc_0,
  input  logic [31:0]       if_ib_pc_1,
  input  logic [31:0]       if_ib_insn_0,
  input  logic [31:0]       if_ib_insn_1,
  input  logic [PTAB_W-1:0] if_ib_ptab_addr_0,
  input  logic [PTAB_W-1:0] if_ib_ptab_addr_1,
  output logic              ib_allin,
  output logic [31:0]       ib_id_pc_0,
  output logic [31:0]       ib_id_pc_1,
  output logic [31:0]       ib_id_insn_0,
  output logic [31:0]       ib_id_insn_1,
  output logic [PTAB_W-1:0] ib_id_ptab_addr_0,
  output logic [PTAB_W-1:0] ib_id_ptab_addr_1,
  output logic              ib_id_valid_0,
  output logic              ib_id_valid_1,
  output logic              ib_valid_ns,
  input  logic              id_allin
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       pc_mem_r   [DEPTH];
  logic [31:0]       insn_mem_r [DEPTH];
  logic [PTAB_W-1:0] ptab_mem_r [DEPTH];

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic             allin_s;
  logic             valid_0_s;
  logic             valid_1_s;
  logic             push_fire_s;
  logic             pop_fire_s;
  logic [1:0]       push_n_s;
  logic [1:0]       pop_n_s;
  logic [PTR_W-1:0] lane1_idx_s;
  logic [PTR_W-1:0] head_p1_s;

  // Flow control and per-cycle push/pop amounts, all from current state.
  always_comb begin
    allin_s     = (count_r <= CNT_W'(DEPTH - 2));
    valid_0_s   = (count_r >= CNT_W'(1));
    valid_1_s   = (count_r >= CNT_W'(2));
    push_fire_s = if_ib_valid_ns & allin_s;
    pop_fire_s  = valid_0_s & id_allin;
    if (push_fire_s) begin
      push_n_s = {1'b0, if_ib_valid_0} + {1'b0, if_ib_valid_1};
    end else begin
      push_n_s = 2'd0;
    end
    if (pop_fire_s) begin
      pop_n_s = valid_1_s ? 2'd2 : 2'd1;
    end else begin
      pop_n_s = 2'd0;
    end
    // A lone lane 1 compacts down to the tail slot.
    lane1_idx_s = tail_r + PTR_W'(if_ib_valid_0);
    head_p1_s   = head_r + PTR_W'(1);
  end

  // Pointer and occupancy registers; flush outranks any push or pop.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(pop_n_s);
      tail_r  <= tail_r + PTR_W'(push_n_s);
      count_r <= count_r + CNT_W'(push_n_s) - CNT_W'(pop_n_s);
    end
  end

  // Entry storage; contents are don't-care outside the head..tail window.
  always_ff @(posedge clk) begin
    if (push_fire_s && !flush) begin
      if (if_ib_valid_0) begin
        pc_mem_r[tail_r]   <= if_ib_pc_0;
        insn_mem_r[tail_r] <= if_ib_insn_0;
        ptab_mem_r[tail_r] <= if_ib_ptab_addr_0;
      end
      if (if_ib_valid_1) begin
        pc_mem_r[lane1_idx_s]   <= if_ib_pc_1;
        insn_mem_r[lane1_idx_s] <= if_ib_insn_1;
        ptab_mem_r[lane1_idx_s] <= if_ib_ptab_addr_1;
      end
    end
  end

  // Output view of the two oldest entries, zeroed when a lane is empty.
  always_comb begin
    ib_allin          = allin_s;
    ib_id_valid_0     = valid_0_s;
    ib_id_valid_1     = valid_1_s;
    ib_valid_ns       = valid_0_s;
    ib_id_pc_0        = 32'd0;
    ib_id_insn_0      = 32'd0;
    ib_id_ptab_addr_0 = '0;
    ib_id_pc_1        = 32'd0;
    ib_id_insn_1      = 32'd0;
    ib_id_ptab_addr_1 = '0;
    if (valid_0_s) begin
      ib_id_pc_0        = pc_mem_r[head_r];
      ib_id_insn_0      = insn_mem_r[head_r];
      ib_id_ptab_addr_0 = ptab_mem_r[head_r];
    end else begin
      ib_id_pc_0        = 32'd0;
    end
    if (valid_1_s) begin
      ib_id_pc_1        = pc_mem_r[head_p1_s];
      ib_id_insn_1      = insn_mem_r[head_p1_s];
      ib_id_ptab_addr_1 = ptab_mem_r[head_p1_s];
    end else begin
      ib_id_pc_1        = 32'd0;
    end
  end

endmodule

// File: tb/tb_insn_buffer.sv
// Self-checking bench for insn_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_insn_buffer;

  localparam int DEPTH  = 8;
  localparam int PTAB_W = 5;

  logic              clk;
  logic              rst_;
  logic              flush;
  logic              if_ib_valid_ns;
  logic              if_ib_valid_0;
  logic              if_ib_valid_1;
  logic [31:0]       if_ib_pc_0;
  logic [31:0]       if_ib_pc_1;
  logic [31:0]       if_ib_insn_0;
  logic [31:0]       if_ib_insn_1;
  logic [PTAB_W-1:0] if_ib_ptab_addr_0;
  logic [PTAB_W-1:0] if_ib_ptab_addr_1;
  logic              ib_allin;
  logic [31:0]       ib_id_pc_0;
  logic [31:0]       ib_id_pc_1;
  logic [31:0]       ib_id_insn_0;
  logic [31:0]       ib_id_insn_1;
  logic [PTAB_W-1:0] ib_id_ptab_addr_0;
  logic [PTAB_W-1:0] ib_id_ptab_addr_1;
  logic              ib_id_valid_0;
  logic              ib_id_valid_1;
  logic              ib_valid_ns;
  logic              id_allin;

  insn_buffer #(.DEPTH(DEPTH), .PTAB_W(PTAB_W)) dut (
    .clk               (clk),
    .rst_              (rst_),
    .flush             (flush),
    .if_ib_valid_ns    (if_ib_valid_ns),
    .if_ib_valid_0     (if_ib_valid_0),
    .if_ib_valid_1     (if_ib_valid_1),
    .if_ib_pc_0        (if_ib_pc_0),
    .if_ib_pc_1        (if_ib_pc_1),
    .if_ib_insn_0      (if_ib_insn_0),
    .if_ib_insn_1      (if_ib_insn_1),
    .if_ib_ptab_addr_0 (if_ib_ptab_addr_0),
    .if_ib_ptab_addr_1 (if_ib_ptab_addr_1),
    .ib_allin          (ib_allin),
    .ib_id_pc_0        (ib_id_pc_0),
    .ib_id_pc_1        (ib_id_pc_1),
    .ib_id_insn_0      (ib_id_insn_0),
    .ib_id_insn_1      (ib_id_insn_1),
    .ib_id_ptab_addr_0 (ib_id_ptab_addr_0),
    .ib_id_ptab_addr_1 (ib_id_ptab_addr_1),
    .ib_id_valid_0     (ib_id_valid_0),
    .ib_id_valid_1     (ib_id_valid_1),
    .ib_valid_ns       (ib_valid_ns),
    .id_allin          (id_allin)
  );

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       insn;
    logic [PTAB_W-1:0] ptab;
  } entry_t;

  entry_t q[$];
  int     tests_run = 0;
  int     tests_failed = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the view implied by the model queue.
  task automatic check_model();
    int n = q.size();
    chk("m_valid_ns", 32'(ib_valid_ns),   32'(n >= 1));
    chk("m_valid_0",  32'(ib_id_valid_0), 32'(n >= 1));
    chk("m_valid_1",  32'(ib_id_valid_1), 32'(n >= 2));
    chk("m_allin",    32'(ib_allin),      32'(n <= DEPTH - 2));
    chk("m_pc_0",   ib_id_pc_0,            (n >= 1) ? q[0].pc   : 32'd0);
    chk("m_insn_0", ib_id_insn_0,          (n >= 1) ? q[0].insn : 32'd0);
    chk("m_ptab_0", 32'(ib_id_ptab_addr_0), (n >= 1) ? 32'(q[0].ptab) : 32'd0);
    chk("m_pc_1",   ib_id_pc_1,            (n >= 2) ? q[1].pc   : 32'd0);
    chk("m_insn_1", ib_id_insn_1,          (n >= 2) ? q[1].insn : 32'd0);
    chk("m_ptab_1", 32'(ib_id_ptab_addr_1), (n >= 2) ? 32'(q[1].ptab) : 32'd0);
  endtask

  task automatic drive(input logic vns, input logic v0, input logic v1,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic ida, input logic fl);
    if_ib_valid_ns    = vns;
    if_ib_valid_0     = v0;
    if_ib_valid_1     = v1;
    if_ib_pc_0        = p0;
    if_ib_pc_1        = p1;
    if_ib_insn_0      = p0 ^ 32'h2400_0000;
    if_ib_insn_1      = p1 ^ 32'h2400_0000;
    if_ib_ptab_addr_0 = PTAB_W'(p0[6:2]);
    if_ib_ptab_addr_1 = PTAB_W'(p1[6:2]);
    id_allin          = ida;
    flush             = fl;
  endtask

  // One clock: apply the buffer's rules to the model at the edge, check at negedge.
  task automatic cycle();
    int     n;
    entry_t e;
    @(posedge clk);
    n = q.size();
    if (flush) begin
      q.delete();
    end else begin
      if (id_allin && n >= 1) begin
        for (int k = 0; k < ((n >= 2) ? 2 : 1); k++) void'(q.pop_front());
      end
      if (if_ib_valid_ns && n <= DEPTH - 2) begin
        if (if_ib_valid_0) begin
          e.pc = if_ib_pc_0; e.insn = if_ib_insn_0; e.ptab = if_ib_ptab_addr_0;
          q.push_back(e);
        end
        if (if_ib_valid_1) begin
          e.pc = if_ib_pc_1; e.insn = if_ib_insn_1; e.ptab = if_ib_ptab_addr_1;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic push2(input logic [31:0] pc);
    drive(1'b1, 1'b1, 1'b1, pc, pc + 32'd4, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic do_flush();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle();
  endtask

  initial begin
    logic [31:0] pc_in;
    logic [31:0] exp_out;
    rst_ = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_valid_ns", 32'(ib_valid_ns), 32'd0);
    chk("rst_allin", 32'(ib_allin), 32'd1);
    chk("rst_pc_0", ib_id_pc_0, 32'd0);
    check_model();
    rst_ = 1'b1;

    // Basic two-instruction push.
    drive(1'b1, 1'b1, 1'b1, 32'h1000, 32'h1004, 1'b0, 1'b0);
    if_ib_insn_0 = 32'h2401_0001; if_ib_insn_1 = 32'h2402_0002;
    if_ib_ptab_addr_0 = 5'd3;     if_ib_ptab_addr_1 = 5'd3;
    cycle();
    chk("t1_valid_0", 32'(ib_id_valid_0), 32'd1);
    chk("t1_valid_1", 32'(ib_id_valid_1), 32'd1);
    chk("t1_pc_0", ib_id_pc_0, 32'h1000);
    chk("t1_pc_1", ib_id_pc_1, 32'h1004);
    chk("t1_insn_0", ib_id_insn_0, 32'h2401_0001);
    chk("t1_allin", 32'(ib_allin), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    chk("t1_drained", 32'(ib_valid_ns), 32'd0);

    // Odd drain of three entries.
    push2(32'h2000);
    drive(1'b1, 1'b1, 1'b0, 32'h2008, 32'd0, 1'b0, 1'b0);
    cycle();
    chk("odd_pc_0", ib_id_pc_0, 32'h2000);
    chk("odd_pc_1", ib_id_pc_1, 32'h2004);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    chk("odd_last_pc_0", ib_id_pc_0, 32'h2008);
    chk("odd_last_valid_1", 32'(ib_id_valid_1), 32'd0);
    chk("odd_last_pc_1", ib_id_pc_1, 32'd0);
    cycle();
    chk("odd_empty", 32'(ib_valid_ns), 32'd0);

    // Fill to seven; a two-lane offer must then be refused, even with a pop.
    do_flush();
    push2(32'h6000); push2(32'h6008); push2(32'h6010);
    chk("fill6_allin", 32'(ib_allin), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h6018, 32'd0, 1'b0, 1'b0);
    cycle();
    chk("fill7_allin", 32'(ib_allin), 32'd0);
    push2(32'h7000);
    chk("fill7_hold_allin", 32'(ib_allin), 32'd0);
    chk("fill7_hold_pc_0", ib_id_pc_0, 32'h6000);
    drive(1'b1, 1'b1, 1'b1, 32'h7000, 32'h7004, 1'b1, 1'b0);
    cycle();
    chk("fill5_allin", 32'(ib_allin), 32'd1);
    chk("fill5_pc_0", ib_id_pc_0, 32'h6008);

    // Full buffer, then flush alongside a push and a pop.
    do_flush();
    push2(32'h8000); push2(32'h8008); push2(32'h8010); push2(32'h8018);
    chk("full_allin", 32'(ib_allin), 32'd0);
    chk("full_valid_1", 32'(ib_id_valid_1), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h9000, 32'h9004, 1'b1, 1'b1);
    cycle();
    chk("flush_valid_ns", 32'(ib_valid_ns), 32'd0);
    chk("flush_allin", 32'(ib_allin), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b0, 1'b0);
    cycle();
    chk("post_flush_pc_0", ib_id_pc_0, 32'h3000);

    // Wrap-around: steady 2-in/2-out with sequential PCs.
    do_flush();
    pc_in = 32'h5000;
    exp_out = 32'h5000;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, pc_in, pc_in + 32'd4, 1'b1, 1'b0);
      cycle();
      pc_in += 32'd8;
      chk("wrap_pc_0", ib_id_pc_0, exp_out);
      chk("wrap_pc_1", ib_id_pc_1, exp_out + 32'd4);
      exp_out += 32'd8;
    end

    // Lane-1-only push compacts into lane 0.
    do_flush();
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'h4004, 1'b0, 1'b0);
    cycle();
    chk("l1only_pc_0", ib_id_pc_0, 32'h4004);
    chk("l1only_valid_1", 32'(ib_id_valid_1), 32'd0);

    // Asynchronous reset pulse between clock edges.
    push2(32'hA000);
    idle();
    #2 rst_ = 1'b0;
    #1;
    chk("arst_valid_ns", 32'(ib_valid_ns), 32'd0);
    chk("arst_valid_1", 32'(ib_id_valid_1), 32'd0);
    chk("arst_pc_0", ib_id_pc_0, 32'd0);
    chk("arst_allin", 32'(ib_allin), 32'd1);
    q.delete();
    #1 rst_ = 1'b1;
    cycle();

    // Randomized traffic with phases of slow and fast draining.
    for (int i = 0; i < 600; i++) begin
      logic ida;
      if (((i / 50) % 2) == 0) ida = ($urandom_range(0, 3) == 0);
      else                     ida = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            $urandom, $urandom, ida, $urandom_range(0, 40) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
